// File: rtl/main_fsm.sv
// main_fsm: Moore control FSM for the multicycle RV32I datapath
//   in : clk, reset_n (async, active-low), op (Instr[6:0]), zero (ALU flag)
//   out: pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//        alu_src_b, alu_op (to alu_decoder), reg_write, branch, illegal,
//        instr_done (retire pulse), retired (count), state (debug)
module main_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             branch,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd15
  } state_t;
  state_t cur, nxt;
  logic pc_update;
  assign state = cur;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cur <= FETCH;
    else cur <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  // op is only looked at in DECODE and MEMADR, so junk in other states is harmless
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:    nxt = DECODE;
      DECODE:
        case (op)
          7'b0000011,
          7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXECR;
          7'b0010011: nxt = EXECI;
          7'b1100011: nxt = BEQ;
          7'b1101111: nxt = JAL;
          default:    nxt = ILLEGAL_TRAP ? ERROR : FETCH;
        endcase
      MEMADR:   nxt = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      EXECR,
      EXECI,
      JAL:      nxt = ALUWB;
      MEMWB,
      MEMWRITE,
      ALUWB,
      BEQ:      nxt = FETCH;
      ERROR:    nxt = ERROR;
      default:  nxt = FETCH;
    endcase
  end
  always_comb begin
    pc_update  = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ERROR:    illegal = 1'b1;
      default: ;
    endcase
  end
  // branch is 0 outside BEQ, so zero only matters there
  assign pc_write = pc_update | (branch & zero);
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: scoreboard bench for main_fsm (default, trapping and 4-bit counter instances)
module tb_main_fsm;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       zero = 1'b0;
  logic [6:0] op = 7'h7f;
  always #5 clk = ~clk;
  // ctl packing: {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, branch, illegal, instr_done}
  wire [15:0] m_c, t_c, s_c;
  wire [3:0]  m_s, t_s, s_s, s_r;
  wire [31:0] m_r, t_r;
  main_fsm #(.ILLEGAL_TRAP(1'b0), .CNT_W(32)) u_main (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .pc_write(m_c[15]), .adr_src(m_c[14]), .mem_write(m_c[13]), .ir_write(m_c[12]),
    .result_src(m_c[11:10]), .alu_src_a(m_c[9:8]), .alu_src_b(m_c[7:6]), .alu_op(m_c[5:4]),
    .reg_write(m_c[3]), .branch(m_c[2]), .illegal(m_c[1]), .instr_done(m_c[0]),
    .retired(m_r), .state(m_s)
  );
  main_fsm #(.ILLEGAL_TRAP(1'b1), .CNT_W(32)) u_trap (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .pc_write(t_c[15]), .adr_src(t_c[14]), .mem_write(t_c[13]), .ir_write(t_c[12]),
    .result_src(t_c[11:10]), .alu_src_a(t_c[9:8]), .alu_src_b(t_c[7:6]), .alu_op(t_c[5:4]),
    .reg_write(t_c[3]), .branch(t_c[2]), .illegal(t_c[1]), .instr_done(t_c[0]),
    .retired(t_r), .state(t_s)
  );
  main_fsm #(.ILLEGAL_TRAP(1'b0), .CNT_W(4)) u_small (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .pc_write(s_c[15]), .adr_src(s_c[14]), .mem_write(s_c[13]), .ir_write(s_c[12]),
    .result_src(s_c[11:10]), .alu_src_a(s_c[9:8]), .alu_src_b(s_c[7:6]), .alu_op(s_c[5:4]),
    .reg_write(s_c[3]), .branch(s_c[2]), .illegal(s_c[1]), .instr_done(s_c[0]),
    .retired(s_r), .state(s_s)
  );
  typedef struct {
    logic [3:0]  s;
    logic [3:0]  ts;
    logic [15:0] c;
    logic [15:0] tc;
    logic [31:0] r;
    logic [31:0] tr;
  } rec_t;
  rec_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mret = 0;
  logic [31:0] tret = 0;
  logic        terr = 1'b0;
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic z);
    case (s)
      4'd0:    return 16'b1_0_0_1_10_00_10_00_0_0_0_0;
      4'd1:    return 16'b0_0_0_0_00_01_01_00_0_0_0_0;
      4'd2:    return 16'b0_0_0_0_00_10_01_00_0_0_0_0;
      4'd3:    return 16'b0_1_0_0_00_00_00_00_0_0_0_0;
      4'd4:    return 16'b0_0_0_0_01_00_00_00_1_0_0_1;
      4'd5:    return 16'b0_1_1_0_00_00_00_00_0_0_0_1;
      4'd6:    return 16'b0_0_0_0_00_10_00_10_0_0_0_0;
      4'd7:    return 16'b0_0_0_0_00_10_01_10_0_0_0_0;
      4'd8:    return 16'b0_0_0_0_00_00_00_00_1_0_0_1;
      4'd9:    return {z, 15'b0_0_0_00_10_00_01_0_1_0_1};
      4'd10:   return 16'b1_0_0_0_00_01_10_00_0_0_0_0;
      4'd15:   return 16'b0_0_0_0_00_00_00_00_0_0_1_0;
      default: return 16'hxxxx;
    endcase
  endfunction
  task automatic push(input logic [3:0] s);
    rec_t e;
    e.s  = s;
    e.ts = terr ? 4'd15 : s;
    e.c  = exp_ctl(e.s, zero);
    e.tc = exp_ctl(e.ts, zero);
    e.r  = mret;
    e.tr = tret;
    q.push_back(e);
    if (e.c[0]) mret++;
    if (e.tc[0]) tret++;
  endtask
  // seq lists expected states as hex nibbles, first state leftmost
  task automatic instr(input logic [6:0] o, input logic z, input int n, input logic [19:0] seq);
    for (int i = 0; i < n; i++) begin
      logic [3:0] s;
      s = seq[19-4*i -: 4];
      op = (s == 4'd1 || s == 4'd2) ? o : 7'h7f;
      zero = z;
      push(s);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    mret = 0;
    tret = 0;
    terr = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(4'd0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask
  task automatic chk(input string nm, input logic [51:0] act, input logic [51:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got state/ctl/retired %h, want %h", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    rec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("main", {m_s, m_c, m_r}, {e.s, e.c, e.r});
      chk("trap", {t_s, t_c, t_r}, {e.ts, e.tc, e.tr});
      chk("cnt4", {s_s, s_c, 28'd0, s_r}, {e.s, e.c, 28'd0, e.r[3:0]});
    end
  end
  initial begin
    @(posedge clk);
    #1;
    do_reset(2);
    instr(7'b0000011, 1'b0, 5, 20'h01234);
    instr(7'b0100011, 1'b0, 4, 20'h01250);
    instr(7'b1100011, 1'b1, 3, 20'h01900);
    instr(7'b1100011, 1'b0, 3, 20'h01900);
    instr(7'b0110011, 1'b0, 4, 20'h01680);
    instr(7'b0010011, 1'b1, 4, 20'h01780);
    instr(7'b1101111, 1'b0, 4, 20'h01a80);
    instr(7'b1111111, 1'b0, 2, 20'h01000);
    terr = 1'b1;
    for (int k = 0; k < 3; k++) instr(7'b0110011, 1'b0, 4, 20'h01680);
    instr(7'b0000011, 1'b0, 3, 20'h01200);
    #1;
    do_reset(2);
    for (int k = 0; k < 17; k++) instr(7'b0110011, 1'b0, 4, 20'h01680);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending records, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
